// File: rtl/field_feedback_responder.sv
// Field-side responder: synchronises and debounces four sensor inputs into Ok levels,
// and raises a sticky per-channel fault when a command stays unconfirmed too long.
module field_feedback_responder #(
    parameter int DEB_W   = 4,
    parameter int DEB_CNT = 10,
    parameter int TO_W    = 8,
    parameter int TO_CNT  = 200
) (
    input  logic       Ck,
    input  logic       Clr,
    input  logic [3:0] Cmd,
    input  logic [3:0] Raw,
    input  logic       Fault_clr,
    output logic [3:0] Ok,
    output logic [3:0] Fault,
    output logic       Any_fault,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WATCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CNT - 1);

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] w_watch;

    // Raw is asynchronous to Ck; only r_s2 is used past this point.
    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            r_s1 <= 4'b0;
            r_s2 <= 4'b0;
        end else begin
            r_s1 <= Raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [DEB_W-1:0] r_dcnt;
        logic             r_ok;
        logic [TO_W-1:0]  r_tcnt;
        logic             r_fault;
        state_t           r_state;

        always_ff @(posedge Ck or negedge Clr) begin
            if (!Clr) begin
                r_dcnt <= '0;
                r_ok   <= 1'b0;
            end else if (r_s2[k] == r_ok) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DEB_LAST) begin
                r_ok   <= r_s2[k];
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end

        // Confirmation or command drop is tested before the terminal count,
        // so either one arriving on the last cycle suppresses the fault.
        always_ff @(posedge Ck or negedge Clr) begin
            if (!Clr) begin
                r_state <= ST_IDLE;
                r_tcnt  <= '0;
                r_fault <= 1'b0;
            end else begin
                case (r_state)
                    ST_FAULT: begin
                        if (Fault_clr) begin
                            r_state <= ST_IDLE;
                            r_tcnt  <= '0;
                            r_fault <= 1'b0;
                        end
                    end
                    ST_IDLE: begin
                        if (Cmd[k] && !r_ok) begin
                            r_state <= ST_WATCH;
                            r_tcnt  <= '0;
                        end
                    end
                    ST_WATCH: begin
                        if (r_ok || !Cmd[k]) begin
                            r_state <= ST_IDLE;
                        end else if (r_tcnt == TO_LAST) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tcnt  <= '0;
                        r_fault <= 1'b0;
                    end
                endcase
            end
        end

        assign Ok[k]      = r_ok;
        assign Fault[k]   = r_fault;
        assign w_watch[k] = (r_state == ST_WATCH);
    end

    assign Any_fault = |Fault;
    assign Busy      = |w_watch;

endmodule

// File: doc/field_feedback_responder.md
Name: field_feedback_responder

Overview:
- Field-side responder for the actuator/sensor handshake of the irrigation controller.
- The controller FSMs drive actuator commands (pump/valve outputs) and wait for the matching confirmed sensor level.
- This block closes that loop. It synchronises and debounces four raw field sensors into clean confirmation levels, and it times out any command that is not confirmed.
- Its outputs Ok[3:0] connect directly to the controller's I1..I4 inputs. Cmd[3:0] comes from the controller's O1..O4.

Parameters:
- DEB_W, 4, width of each debounce counter.
- DEB_CNT, 10, consecutive mismatching cycles required to flip a filtered level. Legal range is 1..2^DEB_W-1.
- TO_W, 8, width of each timeout counter.
- TO_CNT, 200, cycles a command may remain unconfirmed before a fault. Legal range is 1..2^TO_W-1.

Ports:
- Ck  in  1  system clock; all state changes on the rising edge.
- Clr  in  1  asynchronous, active-low reset (0 = reset asserted).
- Cmd  in  4  actuator commands; bit k corresponds to O(k+1). Synchronous to Ck.
- Raw  in  4  raw field sensors; asynchronous to Ck; may bounce.
- Fault_clr  in  1  synchronous pulse; clears all sticky faults.
- Ok  out  4  debounced sensor levels; bit k drives I(k+1).
- Fault  out  4  sticky per-channel timeout faults.
- Any_fault  out  1  OR of Fault.
- Busy  out  1  high while any channel is in WATCH.

Behaviour:
- Reset (Clr=0, asynchronous):
  - sync stages, Ok, Fault, all counters = 0; every channel in IDLE.
  - Any_fault = 0, Busy = 0.
  - Reset asserted mid-operation aborts every debounce and timeout immediately; no partial state survives.
- Synchroniser: two flops per Raw bit (s1 <= Raw, s2 <= s1). Only s2 is used downstream.
- Debounce, per channel, independent of Cmd:
  - If s2 == Ok: dcnt <= 0.
  - Else if dcnt == DEB_CNT-1: Ok <= s2, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any bounce back to equality restarts the count from 0.
  - Latency: Raw stable from before edge 0 → Ok flips at edge DEB_CNT+1 (11 with defaults).
- Timeout FSM, per channel, states IDLE / WATCH / FAULT, evaluated in this priority:
  - FAULT: Fault=1. Fault_clr=1 → IDLE, tcnt <= 0. Otherwise stay; Cmd and Ok are ignored.
  - Fault_clr in IDLE or WATCH: no effect.
  - IDLE: Cmd=1 and Ok=0 → WATCH, tcnt <= 0. Cmd=1 with Ok already 1 stays in IDLE.
  - WATCH: checked in order:
    1. Ok=1 → IDLE.
    2. Cmd=0 → IDLE.
    3. tcnt == TO_CNT-1 → FAULT.
    4. Otherwise tcnt <= tcnt+1.
  - Confirmation or command drop on the terminal-count cycle wins; no fault is raised.
  - Entering WATCH at edge e with no confirmation → Fault rises at edge e+TO_CNT.
- Outputs:
  - Fault[k] = (state_k == FAULT), registered with the state.
  - Any_fault and Busy are combinational ORs of registered state; no glitch sources.
  - Ok is not forced low by a fault; it always reflects the filtered field level.
- Counter widths: tcnt and dcnt never exceed their terminal values, so no wrap-around is reachable with legal parameters.

Test Plan:
- Reset check: Clr=0 with Raw=4'hF, Cmd=4'hF → Ok=0, Fault=0, Busy=0, Any_fault=0 throughout reset. Release with Raw still F → Ok=4'hF 11 edges after release.
- Bounce rejection: Raw[0] toggles every 3 cycles for 40 cycles, then holds 1 → Ok[0] stays 0 during toggling and rises exactly 11 edges after the final rising transition.
- Confirmed command: Cmd[1]=1 with Raw[1]=0; Raw[1] rises 20 cycles later → Busy=1 from the edge after Cmd; Ok[1] rises 11 edges after Raw; Busy returns to 0 the next edge; Fault[1] never set.
- Timeout: Cmd[2]=1, Raw[2] held 0 → Fault[2] and Any_fault rise exactly 200 edges after WATCH entry. Then raise Raw[2] → Ok[2]=1 but Fault[2] stays 1. Then pulse Fault_clr → Fault[2]=0 next edge.
- Simultaneous edge: Ok[3] set to rise on the same edge that tcnt reaches 199 → channel returns to IDLE; Fault[3]=0. Repeat with Cmd[3] dropping on the terminal cycle instead → no fault.
- Mid-operation reset: assert Clr=0 while channel 0 is at tcnt=150 and channel 1 is mid-debounce → all outputs 0 asynchronously. After release, a full 200-cycle timeout is required to fault.
